// File: rtl/sad_pkg.sv
// Shared definitions for the UART packet loader: FSM states, error codes
// and the default frame start marker.
package sad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_OVERFLOW = 2'b11;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_assembler.sv
// Collects WORD_BYTES bytes MSB-first into a word; o_word already includes
// the byte being presented so the caller can capture it on the completing edge.
module uart_byte_assembler #(
   parameter int WORD_BYTES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_clear,
   input  logic                    i_byteValid,
   input  logic [7:0]              i_byte,
   output logic [8*WORD_BYTES-1:0] o_word,
   output logic                    o_wordComplete
);

   logic [8*WORD_BYTES-1:0] r_shift;
   logic [2:0]              r_count;

   assign o_word         = (r_shift << 8) | (8*WORD_BYTES)'(i_byte);
   assign o_wordComplete = i_byteValid && (r_count == 3'(WORD_BYTES - 1));

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (i_byteValid) begin
         if (o_wordComplete) begin
            r_shift <= '0;
            r_count <= '0;
         end else begin
            r_shift <= o_word;
            r_count <= r_count + 3'd1;
         end
      end
   end

endmodule

// File: rtl/uart_packet_loader.sv
// Frame loader: waits for a sync byte, emits FRAME_WORDS words with a
// one-word output register, then checks an XOR checksum byte.
module uart_packet_loader
   import sad_pkg::*;
#(
   parameter int         WORD_BYTES     = 2,
   parameter int         FRAME_WORDS    = 3,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    UARTready,
   input  logic [7:0]              data_in,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic [15:0]             word_index,
   output logic                    frame_done,
   output logic                    frame_error,
   output logic [1:0]              error_code,
   output logic                    busy
);

   state_t                  r_state, w_nextState;
   logic [15:0]             r_wordCount;
   logic [7:0]              r_xor;
   logic [31:0]             r_idle;
   logic [8*WORD_BYTES-1:0] r_wordOut;
   logic                    r_wordValid;
   logic [15:0]             r_wordIndex;
   logic                    r_frameDone, r_frameError;
   logic [1:0]              r_errorCode;

   logic [8*WORD_BYTES-1:0] w_word;
   logic                    w_wordComplete;
   logic                    w_timeout;
   logic                    w_loadWord, w_done, w_error;
   logic [1:0]              w_errCode;

   uart_byte_assembler #(.WORD_BYTES(WORD_BYTES)) u_assembler (
      .clock          (clock),
      .reset          (reset),
      .i_clear        (r_state != DATA),
      .i_byteValid    (UARTready && (r_state == DATA)),
      .i_byte         (data_in),
      .o_word         (w_word),
      .o_wordComplete (w_wordComplete)
   );

   // A byte arriving on the expiry cycle still counts, so timeout needs !UARTready.
   assign w_timeout = (r_state != IDLE) && !UARTready &&
                      (r_idle == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_nextState = r_state;
      w_loadWord  = 1'b0;
      w_done      = 1'b0;
      w_error     = 1'b0;
      w_errCode   = ERR_NONE;
      case (r_state)
         IDLE: begin
            if (UARTready && (data_in == SYNC_BYTE)) w_nextState = DATA;
         end
         DATA: begin
            if (w_timeout) begin
               w_error     = 1'b1;
               w_errCode   = ERR_TIMEOUT;
               w_nextState = IDLE;
            end else if (w_wordComplete) begin
               if (r_wordValid && !word_ready) begin
                  w_error     = 1'b1;
                  w_errCode   = ERR_OVERFLOW;
                  w_nextState = IDLE;
               end else begin
                  w_loadWord = 1'b1;
                  if (r_wordCount == 16'(FRAME_WORDS - 1)) w_nextState = CHECK;
               end
            end
         end
         CHECK: begin
            if (UARTready) begin
               w_nextState = IDLE;
               if (data_in == r_xor) begin
                  w_done = 1'b1;
               end else begin
                  w_error   = 1'b1;
                  w_errCode = ERR_CHECKSUM;
               end
            end else if (w_timeout) begin
               w_error     = 1'b1;
               w_errCode   = ERR_TIMEOUT;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wordCount  <= '0;
         r_xor        <= '0;
         r_idle       <= '0;
         r_wordOut    <= '0;
         r_wordValid  <= 1'b0;
         r_wordIndex  <= '0;
         r_frameDone  <= 1'b0;
         r_frameError <= 1'b0;
         r_errorCode  <= ERR_NONE;
      end else begin
         r_frameDone  <= w_done;
         r_frameError <= w_error;
         if (w_error) r_errorCode <= w_errCode;

         if (UARTready || (r_state == IDLE)) r_idle <= '0;
         else                                r_idle <= r_idle + 32'd1;

         if ((r_state == IDLE) && UARTready && (data_in == SYNC_BYTE)) begin
            r_wordCount <= '0;
            r_xor       <= '0;
         end else if ((r_state == DATA) && UARTready) begin
            r_xor <= r_xor ^ data_in;
         end

         // A new word may replace one being accepted on this same edge.
         if (w_loadWord) begin
            r_wordOut   <= w_word;
            r_wordIndex <= r_wordCount;
            r_wordCount <= r_wordCount + 16'd1;
            r_wordValid <= 1'b1;
         end else if (r_wordValid && word_ready) begin
            r_wordValid <= 1'b0;
         end
      end
   end

   assign word_out    = r_wordOut;
   assign word_valid  = r_wordValid;
   assign word_index  = r_wordIndex;
   assign frame_done  = r_frameDone;
   assign frame_error = r_frameError;
   assign error_code  = r_errorCode;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_packet_loader.sv
// Self-checking bench for uart_packet_loader: vector table, directed corner
// sequences and random frames compared against a frame-level model.
module tb_uart_packet_loader;
   import sad_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        UARTready = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic        word_ready = 1'b1;
   logic [15:0] word_out;
   logic        word_valid;
   logic [15:0] word_index;
   logic        frame_done, frame_error, busy;
   logic [1:0]  error_code;

   int checks = 0;
   int errors = 0;

   logic [15:0] gotWord[$];
   logic [15:0] gotIdx[$];
   int          doneCnt = 0;
   int          errCnt = 0;

   always #5 clock = ~clock;

   uart_packet_loader #(
      .WORD_BYTES(2), .FRAME_WORDS(3), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clock(clock), .reset(reset), .UARTready(UARTready), .data_in(data_in),
      .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
      .word_index(word_index), .frame_done(frame_done), .frame_error(frame_error),
      .error_code(error_code), .busy(busy)
   );

   // Consumer side: record every accepted word and count result pulses.
   always @(negedge clock) begin
      if (word_valid && word_ready) begin
         gotWord.push_back(word_out);
         gotIdx.push_back(word_index);
      end
      if (frame_done) doneCnt++;
      if (frame_error) errCnt++;
      if (frame_done && frame_error) begin
         errors++;
         $display("[TB] FAIL doneAndError: actual both high required exclusive");
      end
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: actual timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic [63:0] bytes;
      logic [47:0] words;
      logic        expDone;
      logic [1:0]  expCode;
   } vec_t;

   vec_t vecs [5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      UARTready = 1'b1;
      data_in   = b;
      @(posedge clock); #1;
      UARTready = 1'b0;
      repeat (gap) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic clearMonitor();
      gotWord.delete();
      gotIdx.delete();
      doneCnt = 0;
      errCnt  = 0;
   endtask

   task automatic checkLatency(input logic [15:0] w, input int idx);
      @(negedge clock);
      checkOutput("latValid", 32'(word_valid), 32'd1);
      checkOutput("latWord", 32'(word_out), 32'(w));
      checkOutput("latIndex", 32'(word_index), 32'(idx));
      @(posedge clock); #1;
   endtask

   task automatic checkFrame(input string tag, input logic [47:0] expW, input int n,
                             input logic expDone, input logic expErr, input logic [1:0] expCode);
      repeat (4) @(negedge clock);
      checkOutput({tag, ".words"}, 32'(gotWord.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < gotWord.size()) begin
            checkOutput({tag, ".word"}, 32'(gotWord[i]), 32'(expW[47-16*i -: 16]));
            checkOutput({tag, ".index"}, 32'(gotIdx[i]), 32'(i));
         end
      end
      checkOutput({tag, ".done"}, 32'(doneCnt), 32'(expDone));
      checkOutput({tag, ".error"}, 32'(errCnt), 32'(expErr));
      if (expErr) checkOutput({tag, ".code"}, 32'(error_code), 32'(expCode));
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      @(posedge clock); #1;
      clearMonitor();
   endtask

   task automatic runVector(input string tag, input vec_t v);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(v.bytes[63-8*i -: 8], 0);
         if (i == 2 || i == 4 || i == 6)
            checkLatency(v.words[47-16*(i/2-1) -: 16], i/2 - 1);
      end
      checkFrame(tag, v.words, 3, v.expDone, !v.expDone, v.expCode);
   endtask

   initial begin
      int          t;
      logic [7:0]  b, chk, chkByte;
      logic [47:0] expW;
      logic [7:0]  d [6];
      logic        good;

      vecs[0] = '{64'hA5123456789ABC2E, 48'h123456789ABC, 1'b1, ERR_NONE};
      vecs[1] = '{64'hA5123456789ABC2F, 48'h123456789ABC, 1'b0, ERR_CHECKSUM};
      vecs[2] = '{64'hA50000FFFFA5A500, 48'h0000FFFFA5A5, 1'b1, ERR_NONE};
      vecs[3] = '{64'hA501020304050607, 48'h010203040506, 1'b1, ERR_NONE};
      vecs[4] = '{64'hA5FFFFFFFFFFFF01, 48'hFFFFFFFFFFFF, 1'b0, ERR_CHECKSUM};

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("rstValid", 32'(word_valid), 32'd0);
      checkOutput("rstWord", 32'(word_out), 32'd0);
      checkOutput("rstIndex", 32'(word_index), 32'd0);
      checkOutput("rstDone", 32'(frame_done), 32'd0);
      checkOutput("rstError", 32'(frame_error), 32'd0);
      checkOutput("rstCode", 32'(error_code), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      clearMonitor();

      for (int i = 0; i < 5; i++) runVector($sformatf("vec%0d", i), vecs[i]);

      // Leading noise must be ignored while idle.
      applyStimulus(8'h00, 0);
      applyStimulus(8'hFF, 1);
      applyStimulus(8'h3C, 0);
      @(negedge clock);
      checkOutput("noiseBusy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      runVector("noise", vecs[0]);

      // Inter-byte timeout.
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      applyStimulus(8'h56, 0);
      t = 0;
      while (!frame_error && t < 1100) begin
         @(negedge clock);
         t++;
      end
      checkOutput("timeoutCycle", 32'(t >= 1000 && t <= 1001), 32'd1);
      checkFrame("timeout", 48'h123400000000, 1, 1'b0, 1'b1, ERR_TIMEOUT);
      runVector("afterTimeout", vecs[0]);

      // Overflow: consumer stalls through the second word.
      word_ready = 1'b0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      applyStimulus(8'h56, 0);
      applyStimulus(8'h78, 0);
      @(negedge clock);
      checkOutput("ovfPulse", 32'(frame_error), 32'd1);
      checkOutput("ovfCode", 32'(error_code), 32'(ERR_OVERFLOW));
      checkOutput("ovfValid", 32'(word_valid), 32'd1);
      checkOutput("ovfWord", 32'(word_out), 32'h1234);
      checkOutput("ovfBusy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      word_ready = 1'b1;
      checkFrame("overflow", 48'h123400000000, 1, 1'b0, 1'b1, ERR_OVERFLOW);

      // Accept on the very cycle the next word completes: no error.
      word_ready = 1'b0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      applyStimulus(8'h56, 0);
      UARTready  = 1'b1;
      data_in    = 8'h78;
      word_ready = 1'b1;
      @(posedge clock); #1;
      UARTready  = 1'b0;
      word_ready = 1'b0;
      @(negedge clock);
      checkOutput("sameValid", 32'(word_valid), 32'd1);
      checkOutput("sameWord", 32'(word_out), 32'h5678);
      checkOutput("sameIndex", 32'(word_index), 32'd1);
      checkOutput("sameNoErr", 32'(frame_error), 32'd0);
      @(posedge clock); #1;
      word_ready = 1'b1;
      applyStimulus(8'h9A, 0);
      applyStimulus(8'hBC, 0);
      checkLatency(16'h9ABC, 2);
      applyStimulus(8'h2E, 0);
      checkFrame("sameCycle", 48'h123456789ABC, 3, 1'b1, 1'b0, ERR_NONE);

      // Reset mid-frame with a pending word and a stale error code.
      word_ready = 1'b0;
      applyStimulus(8'hA5, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      applyStimulus(8'h56, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midRstValid", 32'(word_valid), 32'd0);
      checkOutput("midRstWord", 32'(word_out), 32'd0);
      checkOutput("midRstCode", 32'(error_code), 32'd0);
      checkOutput("midRstError", 32'(frame_error), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      word_ready = 1'b1;
      checkFrame("midReset", 48'h0, 0, 1'b0, 1'b0, ERR_NONE);
      runVector("afterReset", vecs[0]);

      // Random frames against a frame-level model: words are byte pairs,
      // checksum is the XOR of all data bytes.
      for (int f = 0; f < 20; f++) begin
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            applyStimulus(b, int'($urandom_range(0, 3)));
         end
         chk  = 8'h00;
         expW = 48'h0;
         for (int k = 0; k < 6; k++) begin
            d[k] = 8'($urandom);
            chk  = chk ^ d[k];
            expW = {expW[39:0], d[k]};
         end
         good    = 1'($urandom_range(0, 1));
         chkByte = good ? chk : (chk ^ 8'($urandom_range(1, 255)));
         applyStimulus(8'hA5, int'($urandom_range(0, 4)));
         for (int k = 0; k < 6; k++) applyStimulus(d[k], int'($urandom_range(0, 4)));
         applyStimulus(chkByte, 0);
         checkFrame($sformatf("rand%0d", f), expW, 3, good, !good, ERR_CHECKSUM);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_packet_loader.md
UART_PACKET_LOADER -- requirements
Module: uart_packet_loader

Interface
REQ-001 Parameter WORD_BYTES, default 2, bytes per output word (legal 1..4), first received byte most significant.
REQ-002 Parameter FRAME_WORDS, default 3, words per frame (legal 1..65535).
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, maximum idle cycles between bytes inside a frame (legal >= 2).
REQ-005 Port clock  input  1  single clock; all logic rising-edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port UARTready  input  1  one-cycle strobe, byte valid on data_in.
REQ-008 Port data_in  input  8  received byte.
REQ-009 Port word_out  output  8*WORD_BYTES  assembled word.
REQ-010 Port word_valid  output  1  word_out valid, held until accepted.
REQ-011 Port word_ready  input  1  consumer accepts word when high with word_valid.
REQ-012 Port word_index  output  16  position of word_out in frame, 0-based.
REQ-013 Port frame_done  output  1  one-cycle pulse on good checksum.
REQ-014 Port frame_error  output  1  one-cycle pulse on abort.
REQ-015 Port error_code  output  2  01 checksum, 10 timeout, 11 overflow; valid with frame_error, held until next error.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, DATA, CHECK; bytes sampled only on cycles with UARTready high.
REQ-018 IDLE: bytes other than SYNC_BYTE discarded; SYNC_BYTE -> DATA, byte/word counters and running XOR cleared.
REQ-019 DATA: each byte shifted into assembler and XORed into running checksum; after WORD_BYTES bytes the word is loaded into word_out, word_valid set the next cycle.
REQ-020 After FRAME_WORDS words complete -> CHECK.
REQ-021 CHECK: next byte compared to running XOR; equal -> frame_done pulse; unequal -> frame_error, code 01; both -> IDLE.
REQ-022 Latency: word_valid rises exactly 1 cycle after the UARTready strobe of the word's last byte.
REQ-023 word_valid clears the cycle after word_valid && word_ready.
REQ-024 Word completing while word_valid && !word_ready -> frame_error, code 11, -> IDLE; pending word kept valid until accepted.
REQ-025 Word completing in the same cycle the pending word is accepted -> no error; new word loaded, word_valid stays high.
REQ-026 Inter-byte counter cleared on every byte, counts in DATA/CHECK; reaching TIMEOUT_CYCLES-1 without byte -> frame_error, code 10, -> IDLE.
REQ-027 Timeout and byte arrival in same cycle: byte wins, no error.
REQ-028 Words emitted before an error are not retracted; partial assembler contents discarded on abort.
REQ-029 SYNC_BYTE inside DATA/CHECK is treated as ordinary data.
REQ-030 frame_done and frame_error never asserted in the same cycle.

Reset
REQ-031 reset forces state IDLE, counters, assembler and XOR to 0.
REQ-032 All outputs 0 the cycle after reset, including word_valid, pending word dropped, error_code 00.
REQ-033 reset mid-frame aborts without frame_error pulse.

Structure
REQ-034 Shared package sad_pkg holds state enum, error code constants (ERR_NONE, ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERFLOW) and default SYNC_BYTE.
REQ-035 One sub-module uart_byte_assembler (WORD_BYTES shift register, byte counter, word-complete strobe); FSM, timeout, checksum, output register in top.

Verification (WORD_BYTES=2, FRAME_WORDS=3, TIMEOUT_CYCLES=1000)
REQ-036 Bytes A5,12,34,56,78,9A,BC,2E -> words 1234/5678/9ABC with index 0/1/2, then frame_done pulse, busy low.
REQ-037 Same frame with checksum byte 2F -> three words, frame_error, error_code 01.
REQ-038 Bytes 00,FF,3C then good frame -> leading bytes ignored, identical result to REQ-036.
REQ-039 A5,12,34,56 then 1000 idle cycles -> word 1234 only, frame_error code 10, IDLE; following full frame completes normally.
REQ-040 word_ready held low through second word -> word 1234 stays valid, frame_error code 11; word_ready pulsed on 2nd-word cycle instead -> no error.
REQ-041 reset asserted after byte 56 -> all outputs 0 next cycle, no error pulse; subsequent REQ-036 frame passes.
